// File: rtl/usr_pkg.sv
// usr_pkg: shared encodings for the universal shift register command path.
//   - USR_SEL_* : register mode-select values driven on usr_sel
//   - CMD_*     : command op codes accepted on cmd_op
//   - usr_state_e : sequencer FSM states
package usr_pkg;

  localparam logic [1:0] USR_SEL_HOLD = 2'b00;
  localparam logic [1:0] USR_SEL_SHR  = 2'b01;
  localparam logic [1:0] USR_SEL_SHL  = 2'b10;
  localparam logic [1:0] USR_SEL_LOAD = 2'b11;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_SHR  = 2'b01;
  localparam logic [1:0] CMD_SHL  = 2'b10;
  localparam logic [1:0] CMD_ROR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } usr_state_e;

endpackage

// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl: command sequencer for a universal shift register.
// Accepts one command (load / shift right / shift left / rotate right) over a
// valid/ready handshake, drives the register's mode and data lines for the
// required number of cycles, then pulses done for one cycle.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_op            00 load, 01 shift right, 10 shift left, 11 rotate right
//   cmd_cnt           shift cycles (ignored for load)
//   cmd_data          parallel load value
//   cmd_sin           serial fill bit for shifts
//   usr_q             register contents (rotate feedback / readback)
//   usr_sel           register mode: 00 hold, 01 shr, 10 shl, 11 load
//   usr_pin           parallel load data (0 when unused)
//   usr_sr_in         serial input at MSB for shift right (0 when unused)
//   usr_sl_in         serial input at LSB for shift left (0 when unused)
//   busy, done        command in progress / one-cycle completion pulse
//   rsp_data          (only with USR_SEQ_CTRL_READBACK_EN) usr_q captured at done
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_sin,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       usr_sel,
  output logic [WIDTH-1:0] usr_pin,
  output logic             usr_sr_in,
  output logic             usr_sl_in,
  output logic             busy,
`ifdef USR_SEQ_CTRL_READBACK_EN
  output logic [WIDTH-1:0] rsp_data,
`endif
  output logic             done
);

  usr_state_e       state;
  logic [1:0]       op_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] data_r;
  logic             sin_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      op_r   <= CMD_LOAD;
      cnt_r  <= '0;
      data_r <= '0;
      sin_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r   <= cmd_op;
            data_r <= cmd_data;
            sin_r  <= cmd_sin;
            if (cmd_op == CMD_LOAD) begin
              cnt_r <= '0;
              state <= ST_LOAD;
            end else begin
              cnt_r <= cmd_cnt;
              state <= (cmd_cnt == '0) ? ST_DONE : ST_SHIFT;
            end
          end
        end
        ST_LOAD: state <= ST_DONE;
        ST_SHIFT: begin
          // cnt_r holds the shifts still to perform including this cycle.
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    usr_sel   = USR_SEL_HOLD;
    usr_pin   = '0;
    usr_sr_in = 1'b0;
    usr_sl_in = 1'b0;
    case (state)
      ST_LOAD: begin
        usr_sel = USR_SEL_LOAD;
        usr_pin = data_r;
      end
      ST_SHIFT: begin
        case (op_r)
          CMD_SHL: begin
            usr_sel   = USR_SEL_SHL;
            usr_sl_in = sin_r;
          end
          CMD_ROR: begin
            // LSB fed straight back to MSB gives a rotate on a shift-right mode.
            usr_sel   = USR_SEL_SHR;
            usr_sr_in = usr_q[0];
          end
          default: begin
            usr_sel   = USR_SEL_SHR;
            usr_sr_in = sin_r;
          end
        endcase
      end
      default: ;
    endcase
  end

`ifdef USR_SEQ_CTRL_READBACK_EN
  // usr_q already reflects the finished operation during the done cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 rsp_data <= '0;
    else if (state == ST_DONE) rsp_data <= usr_q;
  end
`else
  logic unused_usr_q;
  assign unused_usr_q = ^usr_q[WIDTH-1:1];
`endif

endmodule

// File: tb/tb_usr_seq_ctrl.sv
module tb_usr_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_sin = 1'b0;
  logic [WIDTH-1:0] usr_q = '0;
  logic [1:0]       usr_sel;
  logic [WIDTH-1:0] usr_pin;
  logic             usr_sr_in;
  logic             usr_sl_in;
  logic             busy;
  logic             done;
`ifdef USR_SEQ_CTRL_READBACK_EN
  logic [WIDTH-1:0] rsp_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_sin(cmd_sin),
    .usr_q(usr_q), .usr_sel(usr_sel), .usr_pin(usr_pin),
    .usr_sr_in(usr_sr_in), .usr_sl_in(usr_sl_in),
    .busy(busy),
`ifdef USR_SEQ_CTRL_READBACK_EN
    .rsp_data(rsp_data),
`endif
    .done(done)
  );

  // Behavioural universal shift register driven by the controller.
  always @(posedge clk) begin
    case (usr_sel)
      2'b01: usr_q <= {usr_sr_in, usr_q[WIDTH-1:1]};
      2'b10: usr_q <= {usr_q[WIDTH-2:0], usr_sl_in};
      2'b11: usr_q <= usr_pin;
      default: ;
    endcase
  end

  // Offer a command and return #1 after the edge that accepted it.
  task automatic accept(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                        input logic [WIDTH-1:0] data, input logic sin);
    int n = 0;
    cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_sin = sin;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Latency counted in edges from the acceptance edge to done high.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: done=%b required 1", done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    checks++;
    if ({busy, done, cmd_ready, usr_sel, usr_pin, usr_sr_in, usr_sl_in} !== {1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b ready=%b sel=%b pin=%b sr=%b sl=%b required 0 0 1 00 0000 0 0",
               busy, done, cmd_ready, usr_sel, usr_pin, usr_sr_in, usr_sl_in);
    end
`ifdef USR_SEQ_CTRL_READBACK_EN
    checks++;
    if (rsp_data !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rsp_data: got %b required 0000", rsp_data);
    end
`endif
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift;
    int saw_done = 0;
    accept(2'b01, 3'd4, 4'b0000, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (usr_sel !== 2'b01 || usr_sr_in !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midshift_active: sel=%b sr=%b busy=%b required 01 1 1", usr_sel, usr_sr_in, busy);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (usr_sel !== 2'b00 || usr_sr_in !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midshift_reset: sel=%b sr=%b busy=%b done=%b required 00 0 0 0", usr_sel, usr_sr_in, busy, done);
    end
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) saw_done++;
    end
    checks++;
    if (saw_done != 0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midshift_after: done_pulses=%0d ready=%b busy=%b required 0 1 0", saw_done, cmd_ready, busy);
    end
  endtask

  task automatic test_load_shr;
    int lat;
    accept(2'b00, 3'd0, 4'b1010, 1'b0);
    checks++;
    if (usr_sel !== 2'b11 || usr_pin !== 4'b1010) begin
      errors++;
      $display("FAIL load_drive: sel=%b pin=%b required 11 1010", usr_sel, usr_pin);
    end
    wait_done(lat);
    checks++;
    if (lat != 2 || usr_q !== 4'b1010) begin
      errors++;
      $display("FAIL load_result: lat=%0d q=%b required 2 1010", lat, usr_q);
    end
    accept(2'b01, 3'd2, 4'b1111, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != 3 || usr_q !== 4'b0010) begin
      errors++;
      $display("FAIL shr_result: lat=%0d q=%b required 3 0010", lat, usr_q);
    end
  endtask

  task automatic test_shl;
    int lat;
    accept(2'b00, 3'd0, 4'b0011, 1'b0);
    wait_done(lat);
    accept(2'b10, 3'd1, 4'b0000, 1'b1);
    checks++;
    if (usr_sel !== 2'b10 || usr_sl_in !== 1'b1 || usr_sr_in !== 1'b0 || usr_pin !== 4'b0000) begin
      errors++;
      $display("FAIL shl_drive: sel=%b sl=%b sr=%b pin=%b required 10 1 0 0000", usr_sel, usr_sl_in, usr_sr_in, usr_pin);
    end
    wait_done(lat);
    checks++;
    if (lat != 2 || usr_sel !== 2'b00 || usr_q !== 4'b0111 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL shl_result: lat=%0d sel=%b q=%b ready=%b required 2 00 0111 0", lat, usr_sel, usr_q, cmd_ready);
    end
  endtask

  task automatic test_ror;
    int lat;
    accept(2'b00, 3'd0, 4'b1000, 1'b0);
    wait_done(lat);
    accept(2'b11, 3'd5, 4'b0000, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != 6 || usr_q !== 4'b0100) begin
      errors++;
      $display("FAIL ror_result: lat=%0d q=%b required 6 0100", lat, usr_q);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    accept(2'b00, 3'd0, 4'b0101, 1'b0);
    wait_done(lat);
    @(posedge clk); #1;
    // cnt=0 shift, with a load offered immediately afterwards and held
    accept(2'b01, 3'd0, 4'b0000, 1'b1);
    cmd_op = 2'b00; cmd_data = 4'b1111; cmd_valid = 1'b1;
    checks++;
    if (done !== 1'b1 || usr_sel !== 2'b00 || cmd_ready !== 1'b0 || busy !== 1'b1 || usr_q !== 4'b0101) begin
      errors++;
      $display("FAIL cnt0_done: done=%b sel=%b ready=%b busy=%b q=%b required 1 00 0 1 0101",
               done, usr_sel, cmd_ready, busy, usr_q);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || usr_q !== 4'b0101) begin
      errors++;
      $display("FAIL b2b_idle: ready=%b busy=%b q=%b required 1 0 0101", cmd_ready, busy, usr_q);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (usr_sel !== 2'b11 || usr_pin !== 4'b1111 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: sel=%b pin=%b busy=%b required 11 1111 1", usr_sel, usr_pin, busy);
    end
    wait_done(lat);
    checks++;
    if (lat != 2 || usr_q !== 4'b1111) begin
      errors++;
      $display("FAIL b2b_load: lat=%0d q=%b required 2 1111", lat, usr_q);
    end
  endtask

`ifdef USR_SEQ_CTRL_READBACK_EN
  task automatic test_readback;
    int lat;
    accept(2'b00, 3'd0, 4'b0110, 1'b0);
    wait_done(lat);
    @(posedge clk); #1;
    checks++;
    if (rsp_data !== 4'b0110) begin
      errors++;
      $display("FAIL readback_load: got %b required 0110", rsp_data);
    end
    accept(2'b01, 3'd1, 4'b0000, 1'b0);
    checks++;
    if (rsp_data !== 4'b0110) begin
      errors++;
      $display("FAIL readback_hold: got %b required 0110", rsp_data);
    end
    wait_done(lat);
    @(posedge clk); #1;
    checks++;
    if (rsp_data !== 4'b0011) begin
      errors++;
      $display("FAIL readback_shift: got %b required 0011", rsp_data);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_reset_mid_shift;
    test_load_shr;
    test_shl;
    test_ror;
    test_back_to_back;
`ifdef USR_SEQ_CTRL_READBACK_EN
    test_readback;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usr_seq_ctrl.md
Name: usr_seq_ctrl

Overview:
Command sequencer for the 4-bit universal shift register datapath (hold / shift-right / shift-left / parallel-load).
- Accepts one command at a time over a valid/ready handshake.
- Drives the register's mode-select, parallel-data and serial-input lines for the required number of cycles, then pulses done.
- Sits between the bus-side command source and the shift register instance.

Parameters:
- WIDTH, 4, shift register width in bits.
- CNT_W, 3, width of the shift-count field; must hold 0..2**CNT_W-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  00 load, 01 shift right, 10 shift left, 11 rotate right.
- cmd_cnt  input  CNT_W  number of shift cycles; ignored for load.
- cmd_data  input  WIDTH  parallel value for load.
- cmd_sin  input  1  serial fill bit for shift right/left.
- usr_q  input  WIDTH  current register contents (feedback for rotate).
- usr_sel  output  2  register mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- usr_pin  output  WIDTH  parallel load data.
- usr_sr_in  output  1  serial input entering at MSB on shift right.
- usr_sl_in  output  1  serial input entering at LSB on shift left.
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse at command completion.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; usr_sel=00; usr_pin=0; usr_sr_in=0; usr_sl_in=0; busy=0; done=0; remaining count=0. The command in flight is dropped.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cmd_ready=1, usr_sel=00.
  - On cmd_valid&&cmd_ready, latch op, cnt, data and sin.
  - Next state: LOAD if op=00; DONE if cnt=0 (no shift performed); otherwise SHIFT.
- LOAD: one cycle, usr_sel=11, usr_pin=latched data. Next state DONE.
- SHIFT: exactly cnt cycles, then DONE; remaining count decrements each cycle.
  - op 01: usr_sel=01, usr_sr_in=latched sin.
  - op 10: usr_sel=10, usr_sl_in=latched sin.
  - op 11: usr_sel=01, usr_sr_in=usr_q[0] (combinational feedback), so after cnt cycles the contents have rotated right by cnt.
- DONE: one cycle, done=1, usr_sel=00, cmd_ready=0. Next state IDLE.
- busy=1 in LOAD, SHIFT and DONE.
- cmd_ready is high only in IDLE. Commands offered while busy are not consumed; the source holds them.
- Latency from acceptance edge to done high: load 2 cycles; shift of N≥1 is N+1 cycles; N=0 is 1 cycle.
- Back-to-back: a new command is accepted in the first IDLE cycle after DONE. Minimum issue interval: 3 cycles for load.
- cnt may exceed WIDTH: shifts are executed literally. The register saturates to the fill bit; rotate wraps.
- Unused serial inputs and usr_pin hold 0 when not in use.

Optional Feature:
- USR_SEQ_CTRL_READBACK_EN defined:
  - Adds output rsp_data[WIDTH-1:0], which captures usr_q on the cycle done=1 (i.e. the post-operation value).
  - Held until the next done; reset to 0.
- Undefined: the port and register are absent; no other behaviour changes.

Decomposition:
- Shared package usr_pkg:
  - USR_SEL_HOLD/SHR/SHL/LOAD (2-bit) encodings.
  - CMD_LOAD/SHR/SHL/ROR op encodings.
  - FSM state typedef.
- No sub-module required. An optional down-counter sub-module usr_shift_cnt (load, decrement, zero flag) is acceptable.

Test Plan:
- Reset mid-shift: issue shift-right cnt=4, assert rst=0 after 2 shift cycles -> outputs immediately return to reset values, busy=0, no done pulse, cmd_ready=1 after release.
- Load 4'b1010, then shift right cnt=2 sin=0 against a USR model -> usr_q=4'b0010; done 3 cycles after acceptance.
- Load 4'b0011, then shift left cnt=1 sin=1 -> usr_q=4'b0111; usr_sel sequence 10 then 00.
- Load 4'b1000, then rotate right cnt=5 -> usr_q=4'b0100 (wrap-around); done 6 cycles after acceptance.
- Shift cnt=0 -> done the cycle after acceptance, usr_sel stays 00, usr_q unchanged. A second cmd_valid held during busy is accepted only in the following IDLE cycle.
- With USR_SEQ_CTRL_READBACK_EN: load 4'b0110 -> rsp_data=4'b0110 after done; unchanged until next done.
